// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Word-addressed memory responder on the memory-strobe side of the multicycle
// CPU. A request (MemRead or MemWrite) sampled in IDLE latches Addr/WData and
// the operation. The responder then waits LATENCY cycles and performs the access
// on an internal array. It returns a one-cycle Ready pulse, with RData valid
// for a read. A strobe that is still held after an access is absorbed in HOLD,
// so it cannot start a second access. A request with both strobes high gives a
// single Err pulse and does no access.
//
// Parameters
//   ADDR_W   address width; the array holds 2**ADDR_W words
//   DATA_W   word width
//   LATENCY  wait states between acceptance and access (0..15)
//
// Ports
//   Clk       in   clock, rising edge
//   Reset     in   synchronous, active-high
//   MemRead   in   read strobe (level)
//   MemWrite  in   write strobe (level)
//   Addr      in   word address (from MAR)
//   WData     in   write data (from MDR)
//   RData     out  last read data, registered
//   Ready     out  one-cycle completion pulse, registered
//   Busy      out  high whenever the FSM is not in IDLE
//   Err       out  one-cycle pulse for an illegal request (both strobes)
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int LATENCY = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WData,
    output logic [DATA_W-1:0] RData,
    output logic              Ready,
    output logic              Busy,
    output logic              Err
);

    localparam logic [3:0] LAT = 4'(LATENCY);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_is_write;
    logic [DATA_W-1:0] r_rdata;
    logic              r_ready;
    logic              r_err;

    // Storage array: never cleared by Reset.
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_one_strobe;
    logic w_both_strobes;
    logic w_no_strobe;
    logic w_access;
    logic w_commit;

    assign w_one_strobe   = MemRead ^ MemWrite;
    assign w_both_strobes = MemRead & MemWrite;
    assign w_no_strobe    = ~(MemRead | MemWrite);

    // The access happens on the BUSY edge at which the wait counter reaches zero.
    assign w_access = (r_state == S_BUSY) && (r_cnt == '0);

    // Reset at the same edge discards a pending write.
    assign w_commit = w_access && r_is_write && !Reset;

    always_ff @(posedge Clk) begin
        if (w_commit) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
            r_rdata    <= '0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            // Ready and Err are single-cycle pulses. Their default is low.
            r_ready <= 1'b0;
            r_err   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_one_strobe) begin
                        r_addr     <= Addr;
                        r_wdata    <= WData;
                        r_is_write <= MemWrite;
                        r_cnt      <= LAT;
                        r_state    <= S_BUSY;
                    end else if (w_both_strobes) begin
                        r_err   <= 1'b1;
                        r_state <= S_HOLD;
                    end
                end

                S_BUSY: begin
                    // Only the latched request is used here. Live inputs are ignored.
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        if (!r_is_write) begin
                            r_rdata <= r_mem[r_addr];
                        end
                        r_ready <= 1'b1;
                        r_state <= S_RESP;
                    end
                end

                S_RESP: begin
                    r_state <= w_no_strobe ? S_IDLE : S_HOLD;
                end

                S_HOLD: begin
                    // Stay here until both strobes are seen low. A held strobe
                    // therefore cannot start a second access.
                    if (w_no_strobe) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign RData = r_rdata;
    assign Ready = r_ready;
    assign Err   = r_err;
    assign Busy  = (r_state != S_IDLE);

endmodule
